// File: rtl/mux_scan_n_if.sv
// Bus bundle for mux_scan_n: parallel channel inputs, select/scan control,
// and the valid/ready sample output stage.
interface mux_scan_n_if #(
  parameter int NCH  = 16,
  parameter int W    = 8,
  parameter int SELW = $clog2(NCH)
);
  logic [NCH*W-1:0] in_data;
  logic             en;
  logic             mode;
  logic [SELW-1:0]  sel_in;
  logic             sel_load;
  logic [W-1:0]     out_data;
  logic [SELW-1:0]  out_ch;
  logic             out_valid;
  logic             out_ready;
  logic             sel_err;
  logic             busy;

  modport master (
    output in_data, en, mode, sel_in, sel_load, out_ready,
    input  out_data, out_ch, out_valid, sel_err, busy
  );

  modport slave (
    input  in_data, en, mode, sel_in, sel_load, out_ready,
    output out_data, out_ch, out_valid, sel_err, busy
  );
endinterface

// File: rtl/mux_scan_n.sv
// Registered NCH-channel, W-bit multiplexer with a valid/ready output slot and
// manual or round-robin scan channel selection.
module mux_scan_n #(
  parameter  int NCH   = 16,
  parameter  int W     = 8,
  parameter  int DWELL = 1,
  localparam int SELW  = $clog2(NCH)
) (
  input  logic         clk,
  input  logic         rst_n,
  mux_scan_n_if.slave  bus
);

  localparam logic [SELW:0]   NCH_V      = (SELW+1)'(NCH);
  localparam logic [SELW-1:0] LAST_CH    = SELW'(NCH - 1);
  localparam logic [7:0]      DWELL_LAST = 8'(DWELL - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MANUAL = 2'd1,
    ST_SCAN   = 2'd2
  } state_t;

  state_t          r_state;
  logic [SELW-1:0] r_sel;
  logic [7:0]      r_dcnt;
  logic [W-1:0]    r_out_data;
  logic [SELW-1:0] r_out_ch;
  logic            r_out_valid;
  logic            r_sel_err;
  logic            r_busy;

  logic            w_slot_free;
  logic            w_load_ok;
  logic            w_capture;
  logic [W-1:0]    w_sample;
  logic [SELW-1:0] w_sel_inc;

  // Slot availability, legal select loads, capture decision and scan successor.
  always_comb begin
    w_slot_free = !r_out_valid | bus.out_ready;
    w_load_ok   = bus.sel_load & ({1'b0, bus.sel_in} < NCH_V);
    w_capture   = (r_state != ST_IDLE) & bus.en & w_slot_free;
    w_sample    = bus.in_data[int'(r_sel) * W +: W];
    if (r_sel == LAST_CH) begin
      w_sel_inc = {SELW{1'b0}};
    end else begin
      w_sel_inc = r_sel + SELW'(1);
    end
  end

  // Mode FSM, output slot, select/dwell registers and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_busy      <= 1'b0;
      r_sel       <= {SELW{1'b0}};
      r_dcnt      <= 8'd0;
      r_out_data  <= {W{1'b0}};
      r_out_ch    <= {SELW{1'b0}};
      r_out_valid <= 1'b0;
      r_sel_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.en) begin
            r_state <= bus.mode ? ST_SCAN : ST_MANUAL;
            r_busy  <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        ST_MANUAL, ST_SCAN: begin
          if (bus.en) begin
            r_state <= bus.mode ? ST_SCAN : ST_MANUAL;
            r_busy  <= 1'b1;
          end else if (w_slot_free) begin
            // Only drop to idle once no unaccepted sample remains.
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_state <= r_state;
            r_busy  <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase

      if (w_capture) begin
        r_out_data  <= w_sample;
        r_out_ch    <= r_sel;
        r_out_valid <= 1'b1;
      end else if (w_slot_free) begin
        r_out_valid <= 1'b0;
      end

      if (bus.sel_load && !w_load_ok) begin
        r_sel_err <= 1'b1;
      end

      // An explicit load overrides any scan step taken on the same capture.
      if (w_load_ok) begin
        r_sel  <= bus.sel_in;
        r_dcnt <= 8'd0;
      end else if (w_capture && (r_state == ST_SCAN)) begin
        if (r_dcnt == DWELL_LAST) begin
          r_dcnt <= 8'd0;
          r_sel  <= w_sel_inc;
        end else begin
          r_dcnt <= r_dcnt + 8'd1;
        end
      end
    end
  end

  assign bus.out_data  = r_out_data;
  assign bus.out_ch    = r_out_ch;
  assign bus.out_valid = r_out_valid;
  assign bus.sel_err   = r_sel_err;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_mux_scan_n.sv
// Bench for mux_scan_n: instance A (16 ch, dwell 1) and instance B (12 ch, dwell 3),
// accepted samples checked against an expected-sample queue per instance.
module tb_mux_scan_n;

  logic clk;
  logic rst_n;

  mux_scan_n_if #(.NCH(16), .W(8)) a_if ();
  mux_scan_n_if #(.NCH(12), .W(8)) b_if ();

  mux_scan_n #(.NCH(16), .W(8), .DWELL(1)) u_a (.clk(clk), .rst_n(rst_n), .bus(a_if));
  mux_scan_n #(.NCH(12), .W(8), .DWELL(3)) u_b (.clk(clk), .rst_n(rst_n), .bus(b_if));

  typedef struct {
    logic [7:0] data;
    logic [3:0] ch;
  } exp_t;

  typedef struct {
    logic [3:0] sel;
    logic [7:0] exp_data;
  } vec_t;

  exp_t qa[$];
  exp_t qb[$];
  vec_t vt[4];
  int   n_cmp;
  int   n_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic pa(input logic [3:0] ch);
    qa.push_back('{data: 8'hA0 + {4'h0, ch}, ch: ch});
  endtask

  task automatic pb(input logic [3:0] ch);
    qb.push_back('{data: 8'h30 + {4'h0, ch}, ch: ch});
  endtask

  // Checks accepted samples at the falling edge, then advances past the next rising edge.
  task automatic cyc();
    exp_t e;
    @(negedge clk);
    if (rst_n && a_if.out_valid && a_if.out_ready) begin
      if (qa.size() == 0) begin
        chk("a_unexpected", 32'(a_if.out_ch), 32'hFFFF);
      end else begin
        e = qa.pop_front();
        chk("a_data", 32'(a_if.out_data), 32'(e.data));
        chk("a_ch", 32'(a_if.out_ch), 32'(e.ch));
      end
    end
    if (rst_n && b_if.out_valid && b_if.out_ready) begin
      if (qb.size() == 0) begin
        chk("b_unexpected", 32'(b_if.out_ch), 32'hFFFF);
      end else begin
        e = qb.pop_front();
        chk("b_data", 32'(b_if.out_data), 32'(e.data));
        chk("b_ch", 32'(b_if.out_ch), 32'(e.ch));
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    vt[0] = '{sel: 4'd5,  exp_data: 8'hA5};
    vt[1] = '{sel: 4'd15, exp_data: 8'hAF};
    vt[2] = '{sel: 4'd0,  exp_data: 8'hA0};
    vt[3] = '{sel: 4'd9,  exp_data: 8'hA9};

    for (int c = 0; c < 16; c++) a_if.in_data[c*8 +: 8] = 8'hA0 + 8'(c);
    for (int c = 0; c < 12; c++) b_if.in_data[c*8 +: 8] = 8'h30 + 8'(c);
    a_if.en = 1'b0; a_if.mode = 1'b0; a_if.sel_in = 4'd0; a_if.sel_load = 1'b0; a_if.out_ready = 1'b1;
    b_if.en = 1'b0; b_if.mode = 1'b0; b_if.sel_in = 4'd0; b_if.sel_load = 1'b0; b_if.out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) cyc();

    chk("rst_out_data", 32'(a_if.out_data), 32'h0);
    chk("rst_out_ch", 32'(a_if.out_ch), 32'h0);
    chk("rst_out_valid", 32'(a_if.out_valid), 32'h0);
    chk("rst_busy", 32'(a_if.busy), 32'h0);
    chk("rst_sel_err", 32'(b_if.sel_err), 32'h0);
    rst_n = 1'b1;

    // Manual select vectors
    for (int i = 0; i < 4; i++) begin
      a_if.en = 1'b0; a_if.sel_in = vt[i].sel; a_if.sel_load = 1'b1;
      cyc();
      a_if.sel_load = 1'b0; a_if.mode = 1'b0; a_if.en = 1'b1;
      repeat (3) qa.push_back('{data: vt[i].exp_data, ch: vt[i].sel});
      repeat (4) cyc();
      chk("man_busy", 32'(a_if.busy), 32'h1);
      a_if.en = 1'b0;
      cyc();
      chk("man_idle_valid", 32'(a_if.out_valid), 32'h0);
      chk("man_idle_busy", 32'(a_if.busy), 32'h0);
    end

    // Scan wrap 14,15,0,1,2,3
    a_if.sel_in = 4'd14; a_if.sel_load = 1'b1;
    cyc();
    a_if.sel_load = 1'b0; a_if.mode = 1'b1; a_if.en = 1'b1;
    pa(4'd14); pa(4'd15); pa(4'd0); pa(4'd1); pa(4'd2); pa(4'd3);
    repeat (7) cyc();
    a_if.en = 1'b0;
    cyc();

    // Backpressure in scan: hold ch 2 for 4 cycles
    a_if.sel_in = 4'd2; a_if.sel_load = 1'b1;
    cyc();
    a_if.sel_load = 1'b0; a_if.mode = 1'b1; a_if.en = 1'b1;
    pa(4'd2); pa(4'd3); pa(4'd4);
    repeat (2) cyc();
    a_if.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("bp_valid", 32'(a_if.out_valid), 32'h1);
      chk("bp_ch", 32'(a_if.out_ch), 32'h2);
      chk("bp_data", 32'(a_if.out_data), 32'hA2);
    end
    a_if.out_ready = 1'b1;
    repeat (2) cyc();
    a_if.en = 1'b0;
    cyc();

    // en dropped while a sample is pending
    a_if.sel_in = 4'd7; a_if.sel_load = 1'b1;
    cyc();
    a_if.sel_load = 1'b0; a_if.mode = 1'b0; a_if.en = 1'b1;
    cyc();
    a_if.out_ready = 1'b0;
    cyc();
    a_if.en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      cyc();
      chk("pend_valid", 32'(a_if.out_valid), 32'h1);
      chk("pend_busy", 32'(a_if.busy), 32'h1);
      chk("pend_ch", 32'(a_if.out_ch), 32'h7);
    end
    pa(4'd7);
    a_if.out_ready = 1'b1;
    cyc();
    chk("pend_done_valid", 32'(a_if.out_valid), 32'h0);
    chk("pend_done_busy", 32'(a_if.busy), 32'h0);

    // Instance B: out-of-range load, then dwell-3 scan across the wrap
    b_if.sel_in = 4'd13; b_if.sel_load = 1'b1;
    cyc();
    b_if.sel_load = 1'b0;
    chk("b_sel_err_set", 32'(b_if.sel_err), 32'h1);
    b_if.mode = 1'b0; b_if.en = 1'b1;
    pb(4'd0); pb(4'd0);
    repeat (3) cyc();
    b_if.en = 1'b0;
    cyc();
    b_if.sel_in = 4'd4; b_if.sel_load = 1'b1;
    cyc();
    chk("b_sel_err_sticky", 32'(b_if.sel_err), 32'h1);
    b_if.sel_in = 4'd10;
    cyc();
    b_if.sel_load = 1'b0; b_if.mode = 1'b1; b_if.en = 1'b1;
    repeat (3) pb(4'd10);
    repeat (3) pb(4'd11);
    repeat (3) pb(4'd0);
    repeat (10) cyc();
    b_if.en = 1'b0;
    cyc();
    chk("b_sel_err_hold", 32'(b_if.sel_err), 32'h1);

    // Asynchronous reset mid-scan; the sample captured just before it is lost
    a_if.sel_in = 4'd5; a_if.sel_load = 1'b1;
    cyc();
    a_if.sel_load = 1'b0; a_if.mode = 1'b1; a_if.en = 1'b1;
    pa(4'd5); pa(4'd6);
    repeat (4) cyc();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(a_if.out_valid), 32'h0);
    chk("arst_ch", 32'(a_if.out_ch), 32'h0);
    chk("arst_data", 32'(a_if.out_data), 32'h0);
    chk("arst_busy", 32'(a_if.busy), 32'h0);
    chk("arst_sel_err", 32'(b_if.sel_err), 32'h0);
    cyc();
    rst_n = 1'b1;
    pa(4'd0); pa(4'd1); pa(4'd2);
    repeat (4) cyc();
    a_if.en = 1'b0;
    cyc();

    for (int k = 0; k < 20 && (qa.size() != 0 || qb.size() != 0); k++) cyc();
    chk("a_drain", 32'(qa.size()), 32'h0);
    chk("b_drain", 32'(qb.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mux_scan_n.md
# mux_scan_n

Parametrised, registered N-channel multiplexer with a valid/ready output stage, and a manual or automatic round-robin channel-scan mode. It generalises the team's fixed 16:1 single-bit combinational mux to NCH channels of W bits each. The block sits between a bank of parallel sources (sensor/status lanes) and a single serial consumer. In scan mode it walks the channels without external sequencing.

## Interface
Parameters:
- NCH, 16: number of input channels, 2..256.
- W, 8: width of each channel in bits, ≥1.
- DWELL, 1: samples emitted per channel before advancing in scan mode, 1..255.
- SELW, $clog2(NCH): channel index width (derived; not overridden).

Ports:
- clk  in  1  single clock, all logic rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_data  in  NCH*W  channel c occupies bits [c*W +: W].
- en  in  1  capture enable.
- mode  in  1  0 = manual select, 1 = auto-scan.
- sel_in  in  SELW  channel index to load.
- sel_load  in  1  load sel_in into the select register this cycle.
- out_data  out  W  captured sample.
- out_ch  out  SELW  channel index of out_data.
- out_valid  out  1  sample available.
- out_ready  in  1  consumer accepts sample.
- sel_err  out  1  sticky: a sel_in ≥ NCH was presented with sel_load.
- busy  out  1  state ≠ IDLE.

## Operation
- State machine states: IDLE, MANUAL, SCAN.
  - IDLE → MANUAL when en & !mode.
  - IDLE → SCAN when en & mode.
  - MANUAL ↔ SCAN follows mode while en = 1.
  - Any state → IDLE when en = 0 and no unaccepted sample is pending (out_valid = 0, or out_valid & out_ready this cycle).
- Select register sel_r (SELW bits) and dwell counter dcnt (8 bits).
- sel_load with sel_in < NCH: sel_r ← sel_in and dcnt ← 0, in any state.
- sel_load with sel_in ≥ NCH: ignored; sel_err ← 1 until reset.
- Slot free = !out_valid | out_ready.
- Capture: in MANUAL or SCAN, with en = 1 and slot free:
  - out_data ← in_data[sel_r*W +: W], out_ch ← sel_r, out_valid ← 1.
  - The channel captured is the sel_r value before any update in the same cycle.
- Slot free with no capture: out_valid ← 0.
- SCAN advance, on each capture:
  - If dcnt = DWELL-1: dcnt ← 0 and sel_r ← (sel_r = NCH-1) ? 0 : sel_r+1.
  - Otherwise dcnt ← dcnt+1.
- MANUAL: sel_r only changes via sel_load; dcnt is held.
- Simultaneous sel_load and scan advance: sel_load wins. The current capture still uses the old sel_r.
- mode or en changes take effect at the next capture only. A pending sample is never dropped or modified.

## Timing
- Reset values: out_data = 0, out_ch = 0, out_valid = 0, sel_err = 0, busy = 0, sel_r = 0, dcnt = 0, state = IDLE.
- Latency: in_data sampled at edge k appears on out_data after edge k; out_valid rises in the same cycle.
- Throughput: one sample per cycle while out_ready = 1.
- Backpressure: while out_valid & !out_ready, out_data, out_ch and out_valid are held stable, and sel_r/dcnt do not advance (except via sel_load).
- Enable to first data: en rising at edge k moves the state out of IDLE at k. The first capture is at edge k+1, so out_valid is high from k+1.
- busy is registered and reflects the state after each edge.
- Reset asserted mid-transfer: all outputs clear immediately and asynchronously; the pending sample is lost.

## Test plan
- Manual select, NCH=16, W=8, in_data channel c = 8'hA0+c, out_ready=1, sel_load sel_in=5, en=1, mode=0 → out_data=8'hA5, out_ch=5 every cycle; sel_in=15 → 8'hAF.
- Scan wrap, DWELL=1, NCH=4 → out_ch sequence 0,1,2,3,0,1 on consecutive cycles. With DWELL=3 → 0,0,0,1,1,1,2,…
- Backpressure: in scan, out_ready=0 for 4 cycles with out_valid=1, out_ch=2 → outputs held at ch 2, no advance. out_ready=1 → next out_ch=2 (if DWELL remaining) or 3.
- NCH=12, sel_load sel_in=13 → sel_r unchanged, sel_err=1 and stays 1 after subsequent valid loads, until rst_n=0.
- en=0 with a pending sample and out_ready=0 → sample held, busy=1. out_ready=1 → out_valid=0 next cycle, busy=0.
- rst_n=0 asynchronously mid-scan → out_valid, out_ch, out_data, busy cleared before the next clk edge. After release, the scan restarts at channel 0.
